// File: rtl/regbank_seq_if.sv
// regbank_seq_if: command handshake and bank-control bundle for the
// register-bank sequencer.
//   cmd_valid/cmd_ready : command handshake (one command at a time)
//   cmd_op/dst/src      : operation and register or pair codes
//   hold                : freeze request from the control unit
//   src_sel/ext_sel     : internal-bus source select
//   reg_en              : one-hot register load enable (by register code)
//   busy/done/err       : execution status
// master drives commands (control unit); slave is the sequencer.
interface regbank_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic       hold;
  logic [2:0] src_sel;
  logic       ext_sel;
  logic [7:0] reg_en;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, hold,
    input  cmd_ready, src_sel, ext_sel, reg_en, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, hold,
    output cmd_ready, src_sel, ext_sel, reg_en, busy, done, err
  );
endinterface

// File: rtl/regbank_seq.sv
// regbank_seq: turns one register-transfer command (MOV, LOAD, XCHG, MOVP)
// into a per-cycle schedule for the 8085 register bank's shared 8-bit bus.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regbank_seq_if.slave (command handshake, hold, bus select,
//           one-hot load enables, busy/done/err)
// TMP_IDX is the register code of the W temporary used by XCHG.
module regbank_seq #(
  parameter logic [2:0] TMP_IDX = 3'd6
) (
  input  logic         clk,
  input  logic         rst_n,
  regbank_seq_if.slave bus
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;
  localparam logic [2:0] R_D = 3'd2;
  localparam logic [2:0] R_E = 3'd3;
  localparam logic [2:0] R_H = 3'd4;
  localparam logic [2:0] R_L = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_MOV, S_LOAD,
    S_X0, S_X1, S_X2, S_X3, S_X4, S_X5,
    S_PH, S_PL, S_ERR
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [2:0] nxt_src;
  logic [2:0] dst_q;
  logic [2:0] src_q;
  logic [7:0] en;
  logic       fin;

  // Code 6 (M) is not a bank register; pair code 11 has no register pair.
  function automatic logic cmd_illegal(input logic [1:0] op,
                                       input logic [2:0] dst,
                                       input logic [2:0] src);
    case (op)
      OP_MOV:  return (dst == 3'd6) || (src == 3'd6);
      OP_LOAD: return (dst == 3'd6);
      OP_XCHG: return 1'b0;
      default: return (dst[1:0] == 2'b11) || (src[1:0] == 2'b11);
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic valid,
                                        input logic [1:0] op,
                                        input logic [2:0] dst,
                                        input logic [2:0] src);
    state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE:
        if (!valid)                      n = S_IDLE;
        else if (cmd_illegal(op, dst, src)) n = S_ERR;
        else begin
          case (op)
            OP_MOV:  n = S_MOV;
            OP_LOAD: n = S_LOAD;
            OP_XCHG: n = S_X0;
            default: n = S_PH;
          endcase
        end
      S_X0:    n = S_X1;
      S_X1:    n = S_X2;
      S_X2:    n = S_X3;
      S_X3:    n = S_X4;
      S_X4:    n = S_X5;
      S_PH:    n = S_PL;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // Bus source for a step. XCHG routes D/H and E/L through W; MOVP maps
  // pair p to high register 2p and low register 2p+1.
  function automatic logic [2:0] step_src(input state_t s, input logic [2:0] src);
    case (s)
      S_MOV:       return src;
      S_X0:        return R_D;
      S_X1:        return R_H;
      S_X2, S_X5:  return TMP_IDX;
      S_X3:        return R_E;
      S_X4:        return R_L;
      S_PH:        return {src[1:0], 1'b0};
      S_PL:        return {src[1:0], 1'b1};
      default:     return 3'd0;
    endcase
  endfunction

  always_comb begin
    nxt     = next_state(state, bus.cmd_valid, bus.cmd_op, bus.cmd_dst, bus.cmd_src);
    nxt_src = step_src(nxt, (state == S_IDLE) ? bus.cmd_src : src_q);
  end

  // Bus-select outputs are registered from the upcoming state so they are
  // stable for the whole step; hold freezes state and these outputs together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dst_q       <= 3'd0;
      src_q       <= 3'd0;
      bus.src_sel <= 3'd0;
      bus.ext_sel <= 1'b0;
      bus.busy    <= 1'b0;
    end else if (!bus.hold) begin
      if (state == S_IDLE && bus.cmd_valid) begin
        dst_q <= bus.cmd_dst;
        src_q <= bus.cmd_src;
      end
      state       <= nxt;
      bus.src_sel <= nxt_src;
      bus.ext_sel <= (nxt == S_LOAD);
      bus.busy    <= (nxt != S_IDLE);
    end
  end

  // Step decode: at most one enable bit per state; fin marks the last step.
  always_comb begin
    en  = 8'h00;
    fin = 1'b0;
    case (state)
      S_MOV, S_LOAD: begin en[dst_q] = 1'b1; fin = 1'b1; end
      S_X0, S_X3:    en[TMP_IDX] = 1'b1;
      S_X1:          en[R_D] = 1'b1;
      S_X2:          en[R_H] = 1'b1;
      S_X4:          en[R_E] = 1'b1;
      S_X5:          begin en[R_L] = 1'b1; fin = 1'b1; end
      S_PH:          en[{dst_q[1:0], 1'b0}] = 1'b1;
      S_PL:          begin en[{dst_q[1:0], 1'b1}] = 1'b1; fin = 1'b1; end
      S_ERR:         fin = 1'b1;
      default:       ;
    endcase
  end

  assign bus.reg_en    = bus.hold ? 8'h00 : en;
  assign bus.done      = fin && !bus.hold;
  assign bus.err       = (state == S_ERR) && !bus.hold;
  assign bus.cmd_ready = rst_n && (state == S_IDLE) && !bus.hold;

endmodule
